// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   Memory-access stage and MEM/WB pipeline register of the 5-stage MIPS core.
//   Takes the EX/MEM register outputs (EM_*), issues word loads/stores to data
//   memory over a req/ack handshake, stalls the upstream pipeline while an
//   access is outstanding and registers the writeback triple (MW_*).
//
// Parameters
//   TIMEOUT        maximum WAIT cycles before an access is aborted
//                  (only meaningful when MEM_TIMEOUT_EN is defined)
//
// Compile-time options
//   MEM_TIMEOUT_EN define to abort accesses that are not acked within TIMEOUT
//                  WAIT cycles; mem_err then pulses on the abort cycle.
//                  Undefined: WAIT holds until ack and mem_err is tied to 0.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   EM_MemRead/EM_MemWrite     load / store in MEM
//   EM_RegWrite, EM_MemtoReg   writeback enable, writeback source select
//   EM_ALUResult               effective address / ALU result
//   EM_WriteData               store data (already forwarded)
//   EM_WBAddr                  destination register
//   dm_req, dm_we              memory request (held until ack), write enable
//   dm_addr, dm_wdata          word address, store data
//   dm_rdata, dm_ack           read data, access complete
//   mem_stall                  freeze PC, IF/ID, ID/EX and EX/MEM
//   mem_misalign               one-cycle pulse on a misaligned access
//   mem_err                    one-cycle pulse on timeout abort
//   MW_RegWrite/WBAddr/WBData  registered writeback triple
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EM_MemRead,
    input  logic        EM_MemWrite,
    input  logic        EM_RegWrite,
    input  logic        EM_MemtoReg,
    input  logic [31:0] EM_ALUResult,
    input  logic [31:0] EM_WriteData,
    input  logic [4:0]  EM_WBAddr,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        mem_err,
    output logic        MW_RegWrite,
    output logic [4:0]  MW_WBAddr,
    output logic [31:0] MW_WBData
);

    // state  | meaning
    // IDLE   | no access outstanding; a new access may start this cycle
    // WAIT   | request issued, holding dm_req until dm_ack (or timeout)
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic        access;
    logic        misaligned;
    logic        timeout;
    logic        complete;
    logic        wb_from_mem;

    logic        mw_regwrite_q, mw_regwrite_d;
    logic [4:0]  mw_wbaddr_q,   mw_wbaddr_d;
    logic [31:0] mw_wbdata_q,   mw_wbdata_d;
    logic        misalign_q,    misalign_d;

    assign access     = EM_MemRead | EM_MemWrite;
    assign misaligned = access & (EM_ALUResult[1:0] != 2'b00);

    // A store wins over a simultaneous load, so only a pure load may take
    // its writeback data from memory.
    assign wb_from_mem = EM_MemRead & ~EM_MemWrite & EM_MemtoReg;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The count equals the number of already-elapsed unacked WAIT cycles, so
    // the TIMEOUT-th unacked WAIT cycle is the one where cnt_q == TIMEOUT-1.
    assign timeout = (state_q == S_WAIT) && !dm_ack &&
                     (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (!dm_ack) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mem_err = timeout;
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign mem_err        = 1'b0;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (dm_req && !dm_ack)      state_d = S_WAIT;
            S_WAIT: if (dm_ack || timeout)      state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    // Output logic. dm_req is gated by rst_n so that it falls immediately
    // when reset is asserted, even while EX/MEM still presents an access.
    always_comb begin
        dm_req = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IDLE:  dm_req = access & ~misaligned;
                S_WAIT:  dm_req = ~timeout;
                default: dm_req = 1'b0;
            endcase
        end
    end

    assign dm_we     = EM_MemWrite;
    assign dm_addr   = EM_ALUResult;
    assign dm_wdata  = EM_WriteData;
    assign mem_stall = dm_req & ~dm_ack;
    assign complete  = dm_req & dm_ack;

    // MEM/WB register next-state
    always_comb begin
        mw_regwrite_d = mw_regwrite_q;
        mw_wbaddr_d   = mw_wbaddr_q;
        mw_wbdata_d   = mw_wbdata_q;
        misalign_d    = 1'b0;

        if ((state_q == S_IDLE) && !access) begin
            mw_regwrite_d = EM_RegWrite;
            mw_wbaddr_d   = EM_WBAddr;
            mw_wbdata_d   = EM_ALUResult;
        end else if ((state_q == S_IDLE) && misaligned) begin
            mw_regwrite_d = 1'b0;
            misalign_d    = 1'b1;
        end else if (complete) begin
            mw_regwrite_d = EM_RegWrite;
            mw_wbaddr_d   = EM_WBAddr;
            mw_wbdata_d   = wb_from_mem ? dm_rdata : EM_ALUResult;
        end else begin
            // Stalled or aborted cycle: insert a bubble.
            mw_regwrite_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mw_regwrite_q <= 1'b0;
            mw_wbaddr_q   <= 5'd0;
            mw_wbdata_q   <= 32'd0;
            misalign_q    <= 1'b0;
        end else begin
            mw_regwrite_q <= mw_regwrite_d;
            mw_wbaddr_q   <= mw_wbaddr_d;
            mw_wbdata_q   <= mw_wbdata_d;
            misalign_q    <= misalign_d;
        end
    end

    assign MW_RegWrite  = mw_regwrite_q;
    assign MW_WBAddr    = mw_wbaddr_q;
    assign MW_WBData    = mw_wbdata_q;
    assign mem_misalign = misalign_q;

endmodule
